// File: rtl/dwt_pass_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dwt_pkg
// Purpose  : Shared constants and FSM encoding for the 2D DWT pass scheduler
//            and the 1D wavelet engine it drives.
// Revision : 1.0 - initial release
// ============================================================================
package dwt_pkg;

  localparam int DWT_IMG_W      = 64;
  localparam int DWT_ADDR_W     = 12;
  localparam int DWT_MAX_LEVELS = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CFG    = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_NEXT   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic DIR_ROW = 1'b0;
  localparam logic DIR_COL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dwt_pass_scheduler_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : dwt_watchdog
// Purpose  : 16-bit saturating cycle counter with clear/enable and an expiry
//            flag raised on the LIMIT-th enabled cycle.
// Revision : 1.0 - initial release
// ============================================================================
module dwt_watchdog #(
  parameter int LIMIT = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] c_last = 16'(LIMIT - 1);
  localparam logic [15:0] c_max  = 16'hFFFF;

  logic [15:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 16'd0;
    end else if (clr) begin
      r_count <= 16'd0;
    end else if (en && (r_count != c_max)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign expired = en && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/dwt_pass_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dwt_pass_scheduler
// Purpose  : Orders row/column passes of a multi-level 2D lifting DWT, hands
//            the 1D engine its geometry and bank, and guards it with a watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module dwt_pass_scheduler
  import dwt_pkg::*;
#(
  parameter int IMG_W       = DWT_IMG_W,
  parameter int ADDR_W      = DWT_ADDR_W,
  parameter int MAX_LEVELS  = DWT_MAX_LEVELS,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        levels_cfg,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        cur_level,
  output logic              eng_start,
  input  logic              eng_done,
  output logic              eng_abort,
  output logic              eng_dir,
  output logic [ADDR_W-1:0] eng_len,
  output logic [ADDR_W-1:0] eng_lines,
  output logic [ADDR_W-1:0] eng_elem_step,
  output logic [ADDR_W-1:0] eng_line_step,
  output logic              eng_src_bank
);

  localparam logic [2:0]        c_max_levels = 3'(MAX_LEVELS);
  localparam logic [ADDR_W-1:0] c_img_w      = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] c_one        = ADDR_W'(1);

  state_t     r_state;
  logic [2:0] r_levels;

  logic w_wd_clr;
  logic w_wd_en;
  logic w_wd_expired;
  logic w_cfg_ok;
  logic w_last_pass;

  assign w_wd_clr    = (r_state == S_LAUNCH);
  assign w_wd_en     = (r_state == S_WAIT);
  assign w_cfg_ok    = (levels_cfg != 3'd0) && (levels_cfg <= c_max_levels);
  assign w_last_pass = (eng_dir == DIR_COL) && (cur_level == (r_levels - 3'd1));

  dwt_watchdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_wd_clr),
    .en      (w_wd_en),
    .expired (w_wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_levels      <= 3'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      cur_level     <= 3'd0;
      eng_start     <= 1'b0;
      eng_abort     <= 1'b0;
      eng_dir       <= DIR_ROW;
      eng_len       <= c_img_w;
      eng_lines     <= c_img_w;
      eng_elem_step <= c_one;
      eng_line_step <= c_img_w;
      eng_src_bank  <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      eng_abort <= 1'b0;
      done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (w_cfg_ok) begin
              r_levels     <= levels_cfg;
              err          <= 1'b0;
              cur_level    <= 3'd0;
              eng_dir      <= DIR_ROW;
              eng_src_bank <= 1'b0;
              r_state      <= S_CFG;
            end else begin
              r_state      <= S_ERR;
            end
          end
        end
        S_CFG: begin
          eng_len   <= c_img_w >> cur_level;
          eng_lines <= c_img_w >> cur_level;
          // Row passes walk contiguous samples; column passes stride by a full row.
          if (eng_dir == DIR_COL) begin
            eng_elem_step <= c_img_w;
            eng_line_step <= c_one;
          end else begin
            eng_elem_step <= c_one;
            eng_line_step <= c_img_w;
          end
          eng_start <= 1'b1;
          r_state   <= S_LAUNCH;
        end
        S_LAUNCH: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A completion on the expiry cycle takes priority over the abort.
          if (eng_done) begin
            r_state <= S_NEXT;
          end else if (w_wd_expired) begin
            eng_abort <= 1'b1;
            r_state   <= S_ERR;
          end
        end
        S_NEXT: begin
          eng_src_bank <= ~eng_src_bank;
          if (eng_dir == DIR_ROW) begin
            eng_dir <= DIR_COL;
          end else begin
            eng_dir   <= DIR_ROW;
            cur_level <= cur_level + 3'd1;
          end
          if (w_last_pass) begin
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_CFG;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        S_ERR: begin
          err     <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dwt_pass_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dwt_pass_scheduler
// Purpose  : Self-checking bench for dwt_pass_scheduler with an engine model
//            and a pass-list reference derived from level/direction rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dwt_pass_scheduler;

  localparam int IMG_W  = 64;
  localparam int ADDR_W = 12;
  localparam int TO_CYC = 100;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [2:0]        levels_cfg;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        cur_level;
  logic              eng_start;
  logic              eng_done;
  logic              eng_abort;
  logic              eng_dir;
  logic [ADDR_W-1:0] eng_len;
  logic [ADDR_W-1:0] eng_lines;
  logic [ADDR_W-1:0] eng_elem_step;
  logic [ADDR_W-1:0] eng_line_step;
  logic              eng_src_bank;

  int checks;
  int errors;

  dwt_pass_scheduler #(
    .IMG_W       (IMG_W),
    .ADDR_W      (ADDR_W),
    .MAX_LEVELS  (4),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .levels_cfg    (levels_cfg),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .cur_level     (cur_level),
    .eng_start     (eng_start),
    .eng_done      (eng_done),
    .eng_abort     (eng_abort),
    .eng_dir       (eng_dir),
    .eng_len       (eng_len),
    .eng_lines     (eng_lines),
    .eng_elem_step (eng_elem_step),
    .eng_line_step (eng_line_step),
    .eng_src_bank  (eng_src_bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Pass p covers level p/2; even passes are rows, odd are columns; bank alternates from 0.
  function automatic logic [63:0] exp_geom(input int p);
    int                lvl;
    logic              d;
    logic              b;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] es;
    logic [ADDR_W-1:0] ls;
    lvl = p / 2;
    d   = (p % 2) == 1;
    b   = (p % 2) == 1;
    len = ADDR_W'(IMG_W >> lvl);
    es  = d ? ADDR_W'(IMG_W) : ADDR_W'(1);
    ls  = d ? ADDR_W'(1) : ADDR_W'(IMG_W);
    return {11'd0, 3'(lvl), d, b, len, len, es, ls};
  endfunction

  function automatic logic [63:0] act_geom();
    return {11'd0, cur_level, eng_dir, eng_src_bank, eng_len, eng_lines, eng_elem_step, eng_line_step};
  endfunction

  function automatic logic [63:0] act_rst();
    return 64'({busy, done, err, eng_start, eng_abort, eng_dir, cur_level, eng_src_bank,
                eng_len, eng_lines, eng_elem_step, eng_line_step});
  endfunction

  function automatic logic [63:0] exp_rst();
    return 64'({6'b0, 3'd0, 1'b0, 12'd64, 12'd64, 12'd1, 12'd64});
  endfunction

  // Runs one job; lat==0 draws a random engine latency per pass; rst_pass>=0 resets mid-job.
  task automatic run_job(input int lv, input int lat, input bit noise, input int rst_pass,
                         input int npass);
    int p, due, s, exp_start, exp_done;
    bit fin;
    p = 0; due = -1; s = -100; exp_start = 2; exp_done = -1; fin = 0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      if (c == 1) chk("err_clear", 64'(err), 64'd0);
      if (c >= 1) chk("busy_noabort", 64'({busy, eng_abort}), 64'd2);
      if (eng_start) begin
        chk("start_cycle", 64'(c), 64'(exp_start));
        chk("pass_in_range", 64'(p < npass), 64'd1);
        chk("geom_launch", act_geom(), exp_geom(p));
        s   = c;
        due = c + ((lat > 0) ? lat : int'($urandom_range(1, 30)));
        p++;
      end
      if (done) begin
        chk("done_cycle", 64'(c), 64'(exp_done));
        chk("done_passes", 64'(p), 64'(npass));
        fin = 1;
      end
      if (rst_pass >= 0 && p == rst_pass && c == s + 4) begin
        rst_n = 1'b0;
        #1;
        chk("rst_async", act_rst(), exp_rst());
        @(posedge clk); #1;
        chk("rst_held", act_rst(), exp_rst());
        rst_n    = 1'b1;
        start    = 1'b0;
        eng_done = 1'b0;
        @(posedge clk); #1;
        return;
      end
      start      = (c == 0) || (noise && c == s + 3);
      levels_cfg = (c == 0) ? lv[2:0] : 3'd5;
      eng_done   = (c == due) || (noise && c == s);
      if (c == due) begin
        chk("geom_hold", act_geom(), exp_geom(p - 1));
        exp_start = c + 3;
        exp_done  = c + 2;
      end
      @(posedge clk); #1;
    end
    start    = 1'b0;
    eng_done = 1'b0;
    if (!fin) chk("job_timeout", 64'd0, 64'd1);
    chk("idle_after", 64'({busy, err, done, eng_src_bank}), 64'd0);
  endtask

  task automatic run_bad(input int lv, input bit exp_err);
    start      = 1'b1;
    levels_cfg = lv[2:0];
    @(posedge clk); #1;
    start = 1'b0;
    chk("bad_busy", 64'({busy, eng_start}), 64'd2);
    @(posedge clk); #1;
    chk("bad_err", 64'({err, busy, eng_start}), 64'({exp_err, 2'b00}));
    repeat (3) begin
      @(posedge clk); #1;
      chk("bad_quiet", 64'({busy, eng_start}), 64'd0);
    end
  endtask

  task automatic run_timeout();
    int s, ab;
    s = -1; ab = -1;
    start      = 1'b1;
    levels_cfg = 3'd1;
    eng_done   = 1'b0;
    for (int c = 0; c < 400 && ab < 0; c++) begin
      if (eng_start) s = c;
      if (eng_abort) ab = c;
      start = (c == 0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("to_start_cycle", 64'(s), 64'd2);
    chk("to_abort_cycle", 64'(ab), 64'(2 + TO_CYC + 1));
    chk("to_after", 64'({err, busy, eng_abort}), 64'd4);
  endtask

  typedef struct {
    int lv;
    int lat;
    bit noise;
    bit exp_err;
    int exp_passes;
  } vec_t;

  vec_t tbl[8];

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    levels_cfg = 3'd0;
    eng_done   = 1'b0;

    tbl[0] = '{1, 10,  1'b0, 1'b0, 2};
    tbl[1] = '{4, 10,  1'b0, 1'b0, 8};
    tbl[2] = '{0, 10,  1'b0, 1'b1, 0};
    tbl[3] = '{5, 10,  1'b0, 1'b1, 0};
    tbl[4] = '{2, 1,   1'b0, 1'b0, 4};
    tbl[5] = '{3, 100, 1'b0, 1'b0, 6};
    tbl[6] = '{7, 10,  1'b0, 1'b1, 0};
    tbl[7] = '{1, 10,  1'b1, 1'b0, 2};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_values", act_rst(), exp_rst());
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Spurious engine completions while idle must not start anything.
    eng_done = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_spurious", 64'({busy, eng_start}), 64'd0);
    end
    eng_done = 1'b0;

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].exp_err) run_bad(tbl[i].lv, tbl[i].exp_err);
      else run_job(tbl[i].lv, tbl[i].lat, tbl[i].noise, -1, tbl[i].exp_passes);
    end

    for (int i = 0; i < 6; i++) begin
      int lv;
      int lat;
      bit nz;
      lv  = int'($urandom_range(1, 4));
      lat = int'($urandom_range(0, 40));
      nz  = 1'($urandom_range(0, 1));
      run_job(lv, lat, nz, -1, 2 * lv);
    end

    run_timeout();
    run_job(1, 10, 1'b0, -1, 2);

    run_job(2, 10, 1'b0, 3, 4);
    chk("post_reset_idle", act_rst(), exp_rst());
    run_job(2, 10, 1'b0, -1, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
